// File: rtl/ss_move_pkg.sv
// Shared encodings for the ss_move data-mover engine: op codes, FSM states and the fill length width.
package ss_move_pkg;

    typedef enum logic [1:0] {
        OP_NONE    = 2'b00,
        OP_DISCARD = 2'b01,
        OP_COPY    = 2'b10,
        OP_FILL    = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_WAIT = 2'b10,
        S_END  = 2'b11
    } state_e;

    localparam int LEN_W = 12;

endpackage

// File: rtl/ss_move_outreg.sv
// Registered destination-side stage shared by COPY and FILL: one cycle from issue to push.
module ss_move_outreg #(
    parameter int DW = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] word,
    input  logic          word_last,
    output logic          putn,
    output logic [DW-1:0] dst,
    output logic          dst_last
);

    // Data returns to zero between pushes so an idle or draining engine presents a clean bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            putn     <= 1'b1;
            dst      <= '0;
            dst_last <= 1'b0;
        end else begin
            putn     <= !push;
            dst      <= push ? word : '0;
            dst_last <= push & word_last;
        end
    end

endmodule

// File: rtl/ss_move.sv
// ss_move: DMA data mover (DISCARD / COPY / FILL) between a FWFT source FIFO and a destination FIFO.
// Optional build macro SS_MOVE_TRISTATE_EN releases the FIFO-side outputs to 'z' while dc selects OP_NONE.
module ss_move
    import ss_move_pkg::*;
#(
    parameter int DW      = 64,
    parameter int CNT_W   = 16,
    parameter int OP_LSB  = 8,
    parameter int LEN_LSB = 12
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             m_enable,
    input  logic [23:0]      dc,
    output logic             m_src_getn,
    input  logic [DW-1:0]    m_src,
    input  logic             m_src_last,
    input  logic             m_src_almost_empty,
    input  logic             m_src_empty,
    output logic             m_dst_putn,
    output logic [DW-1:0]    m_dst,
    output logic             m_dst_last,
    input  logic             m_dst_almost_full,
    input  logic             m_dst_full,
    output logic             m_endn,
    output logic             m_busy,
    output logic [CNT_W-1:0] m_words
);

    state_e           state, state_nxt;
    op_e              op_live, op_q;
    logic [LEN_W-1:0] len;
    logic [LEN_W:0]   remaining;
    logic [CNT_W-1:0] words;
    logic             uses_src, uses_dst, blocked, run, start;
    logic             pop, fill_issue, fill_final, push;
    logic             endn_raw, putn_q, dst_last_q;
    logic [DW-1:0]    dst_q;
    logic             unused_inputs;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] w);
        return (&w) ? w : w + 1'b1;
    endfunction

    assign op_live = op_e'(dc[OP_LSB+1:OP_LSB]);
    assign len     = dc[LEN_LSB+LEN_W-1:LEN_LSB];

    assign uses_src   = (op_q == OP_DISCARD) || (op_q == OP_COPY);
    assign uses_dst   = (op_q == OP_COPY) || (op_q == OP_FILL);
    assign blocked    = (uses_src & m_src_empty) | (uses_dst & (m_dst_almost_full | m_dst_full));
    assign run        = (state == S_RUN);
    assign pop        = run & uses_src & !blocked;
    assign fill_issue = run & (op_q == OP_FILL) & !blocked;
    assign fill_final = fill_issue & (remaining == {{LEN_W{1'b0}}, 1'b1});
    assign push       = (pop & (op_q == OP_COPY)) | fill_issue;
    assign start      = (state == S_IDLE) & m_enable & (op_live != OP_NONE)
                      & ((op_live == OP_FILL) | !m_src_empty);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // A popped last word ends the operation ahead of any blocking condition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_RUN;
            S_RUN: begin
                if (!m_enable)                         state_nxt = S_IDLE;
                else if ((pop & m_src_last) | fill_final) state_nxt = S_END;
                else if (blocked)                      state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (!m_enable)     state_nxt = S_IDLE;
                else if (!blocked) state_nxt = S_RUN;
            end
            S_END:   if (!m_enable) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        endn_raw = (state != S_END);
        m_busy   = (state == S_RUN) || (state == S_WAIT);
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            op_q      <= OP_NONE;
            words     <= '0;
            remaining <= '0;
        end else if (start) begin
            op_q      <= op_live;
            words     <= '0;
            remaining <= {1'b0, len} + 1'b1;
        end else begin
            if (pop | fill_issue) words     <= sat_inc(words);
            if (fill_issue)       remaining <= remaining - 1'b1;
        end
    end

    ss_move_outreg #(.DW(DW)) u_outreg (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .push      (push),
        .word      (fill_issue ? '0 : m_src),
        .word_last (fill_issue ? fill_final : m_src_last),
        .putn      (putn_q),
        .dst       (dst_q),
        .dst_last  (dst_last_q)
    );

    assign m_words = words;

`ifdef SS_MOVE_TRISTATE_EN
    assign m_src_getn = (op_live == OP_NONE) ? 1'bz      : !pop;
    assign m_dst_putn = (op_live == OP_NONE) ? 1'bz      : putn_q;
    assign m_dst      = (op_live == OP_NONE) ? {DW{1'bz}} : dst_q;
    assign m_dst_last = (op_live == OP_NONE) ? 1'bz      : dst_last_q;
    assign m_endn     = (op_live == OP_NONE) ? 1'bz      : endn_raw;
`else
    assign m_src_getn = (op_live == OP_NONE) ? 1'b1 : !pop;
    assign m_dst_putn = (op_live == OP_NONE) ? 1'b1 : putn_q;
    assign m_dst      = (op_live == OP_NONE) ? '0   : dst_q;
    assign m_dst_last = (op_live == OP_NONE) ? 1'b0 : dst_last_q;
    assign m_endn     = (op_live == OP_NONE) ? 1'b1 : endn_raw;
`endif

    // Almost-empty is part of the FIFO interface but the mover only reacts to empty.
    assign unused_inputs = &{1'b0, m_src_almost_empty, dc};

endmodule

// File: tb/tb_ss_move.sv
// Scoreboard bench for ss_move: a FWFT source model feeds the DUT, expected pushes are queued and matched.
module tb_ss_move;
    import ss_move_pkg::*;

    localparam int DW    = 64;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             m_enable;
    logic [23:0]      dc;
    logic             m_src_getn;
    logic [DW-1:0]    m_src;
    logic             m_src_last;
    logic             m_src_almost_empty;
    logic             m_src_empty;
    logic             m_dst_putn;
    logic [DW-1:0]    m_dst;
    logic             m_dst_last;
    logic             m_dst_almost_full;
    logic             m_dst_full;
    logic             m_endn;
    logic             m_busy;
    logic [CNT_W-1:0] m_words;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            cyc;
    } exp_t;

    exp_t         exp_q[$];
    exp_t         e_mon;
    logic [DW:0]  src_q[$];
    int           vectors     = 0;
    int           miscompares = 0;
    int           cyc         = 0;
    int           pops        = 0;
    bit           pop_pend    = 1'b0;
    op_e          cur_op      = OP_NONE;

    ss_move #(.DW(DW), .CNT_W(CNT_W), .OP_LSB(8), .LEN_LSB(12)) dut (
        .wb_clk_i           (clk),
        .wb_rst_i           (rst),
        .m_enable           (m_enable),
        .dc                 (dc),
        .m_src_getn         (m_src_getn),
        .m_src              (m_src),
        .m_src_last         (m_src_last),
        .m_src_almost_empty (m_src_almost_empty),
        .m_src_empty        (m_src_empty),
        .m_dst_putn         (m_dst_putn),
        .m_dst              (m_dst),
        .m_dst_last         (m_dst_last),
        .m_dst_almost_full  (m_dst_almost_full),
        .m_dst_full         (m_dst_full),
        .m_endn             (m_endn),
        .m_busy             (m_busy),
        .m_words            (m_words)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic src_refresh();
        if (src_q.size() == 0) begin
            m_src_empty = 1'b1;
            m_src       = '0;
            m_src_last  = 1'b0;
        end else begin
            m_src_empty = 1'b0;
            m_src       = src_q[0][DW-1:0];
            m_src_last  = src_q[0][DW];
        end
    endtask

    // Source FIFO model: a pop seen mid-cycle retires the head just after the next edge.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (pop_pend) begin
            if (src_q.size() != 0) void'(src_q.pop_front());
            pop_pend = 1'b0;
        end
        src_refresh();
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (!m_src_getn) begin
                pops++;
                if (src_q.size() == 0) check("pop_when_empty", 1, 0);
                else begin
                    pop_pend = 1'b1;
                    if (cur_op == OP_COPY)
                        exp_q.push_back('{src_q[0][DW-1:0], src_q[0][DW], cyc + 1});
                end
            end
            if (!m_dst_putn) begin
                check("push_when_full", m_dst_full, 0);
                if (exp_q.size() == 0) check("unexpected_push", 1, 0);
                else begin
                    e_mon = exp_q.pop_front();
                    check("dst_data", m_dst, e_mon.data);
                    check("dst_last", m_dst_last, e_mon.last);
                    if (e_mon.cyc != 0) check("copy_latency", cyc, e_mon.cyc);
                end
            end
            if (m_dst_almost_full && cur_op == OP_COPY) check("stall_no_pop", m_src_getn, 1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [DW-1:0] base, input int n, input bit last_on_end);
        for (int i = 0; i < n; i++)
            src_q.push_back({(last_on_end && i == n - 1), base + DW'(i)});
        src_refresh();
    endtask

    task automatic start(input op_e op, input logic [11:0] len);
        cur_op     = op;
        dc         = '0;
        dc[23:12]  = len;
        dc[9:8]    = op;
        m_enable   = 1'b1;
    endtask

    task automatic wait_end(input string tag, input int maxc);
        int n = 0;
        while (m_endn !== 1'b0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_endn"}, m_endn, 0);
    endtask

    task automatic finish_op(input string tag, input int nwords);
        check({tag, "_words"}, m_words, nwords);
        check({tag, "_busy_end"}, m_busy, 0);
        tick(2);
        check({tag, "_endn_held"}, m_endn, 0);
        m_enable = 1'b0;
        tick(1);
        check({tag, "_endn_rearm"}, m_endn, 1);
        tick(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; m_enable = 1'b0; dc = '0;
        m_src_almost_empty = 1'b0; m_dst_almost_full = 1'b0; m_dst_full = 1'b0;
        src_refresh();
        #1;
        check("rst_getn", m_src_getn, 1);
        check("rst_putn", m_dst_putn, 1);
        check("rst_endn", m_endn, 1);
        check("rst_busy", m_busy, 0);
        check("rst_words", m_words, 0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // DISCARD: five words, last on the fifth, no pushes.
        pops = 0;
        load(64'h0000_0000_0000_0a01, 5, 1'b1);
        start(OP_DISCARD, 12'd0);
        wait_end("discard", 40);
        check("discard_pops", pops, 5);
        check("discard_dst", m_dst, 0);
        finish_op("discard", 5);

        // COPY: 0x11..0x44 with last on 0x44.
        src_q.push_back({1'b0, 64'h11}); src_q.push_back({1'b0, 64'h22});
        src_q.push_back({1'b0, 64'h33}); src_q.push_back({1'b1, 64'h44});
        src_refresh();
        start(OP_COPY, 12'd0);
        wait_end("copy4", 40);
        finish_op("copy4", 4);

        // COPY with destination stall mid-stream.
        load(64'h0000_0000_0000_0100, 6, 1'b1);
        start(OP_COPY, 12'd0);
        tick(3);
        m_dst_almost_full = 1'b1;
        tick(1);
        m_dst_full = 1'b1;
        check("stall_busy", m_busy, 1);
        tick(2);
        m_dst_almost_full = 1'b0;
        m_dst_full        = 1'b0;
        wait_end("copystall", 40);
        finish_op("copystall", 6);

        // FILL len=2 and len=0.
        pops = 0;
        exp_q.push_back('{64'h0, 1'b0, 0});
        exp_q.push_back('{64'h0, 1'b0, 0});
        exp_q.push_back('{64'h0, 1'b1, 0});
        start(OP_FILL, 12'd2);
        wait_end("fill3", 40);
        check("fill_pops", pops, 0);
        finish_op("fill3", 3);
        exp_q.push_back('{64'h0, 1'b1, 0});
        start(OP_FILL, 12'd0);
        wait_end("fill1", 40);
        finish_op("fill1", 1);

        // COPY with the source running dry, then the last word arriving.
        load(64'h0000_0000_0000_0201, 2, 1'b0);
        start(OP_COPY, 12'd0);
        tick(7);
        check("gap_busy", m_busy, 1);
        check("gap_getn", m_src_getn, 1);
        check("gap_endn", m_endn, 1);
        load(64'h0000_0000_0000_0203, 2, 1'b1);
        wait_end("copygap", 40);
        finish_op("copygap", 4);

        // Abort mid-COPY: back to idle without completion.
        load(64'h0000_0000_0000_0301, 5, 1'b0);
        start(OP_COPY, 12'd0);
        tick(3);
        m_enable = 1'b0;
        tick(1);
        check("abort_busy", m_busy, 0);
        check("abort_endn", m_endn, 1);
        tick(2);
        check("abort_drain", exp_q.size(), 0);
        src_q.delete();
        src_refresh();
        tick(1);

        // Asynchronous reset mid-COPY, then a clean restart.
        load(64'h0000_0000_0000_0401, 6, 1'b1);
        start(OP_COPY, 12'd0);
        tick(3);
        rst = 1'b1;
        #1;
        check("arst_getn", m_src_getn, 1);
        check("arst_putn", m_dst_putn, 1);
        check("arst_dst", m_dst, 0);
        check("arst_last", m_dst_last, 0);
        check("arst_endn", m_endn, 1);
        check("arst_busy", m_busy, 0);
        check("arst_words", m_words, 0);
        exp_q.delete();
        src_q.delete();
        pop_pend = 1'b0;
        m_enable = 1'b0;
        src_refresh();
        tick(2);
        rst = 1'b0;
        tick(1);
        check("post_rst_words", m_words, 0);
        load(64'h0000_0000_0000_0501, 2, 1'b1);
        start(OP_COPY, 12'd0);
        wait_end("restart", 40);
        finish_op("restart", 2);

        check("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
